// File: rtl/state_update_ctrl_pkg.sv
// Shared command/state encodings for the state-register update controller.
package state_update_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_INIT   = 2'd0,
    OP_RUN    = 2'd1,
    OP_STOP   = 2'd2,
    OP_SINGLE = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/state_update_ctrl_if.sv
// Command handshake and model-side strobes for state_update_ctrl.
// Breakpoint signals exist only when STATE_UPDATE_CTRL_BKPT_EN is defined.
interface state_update_ctrl_if #(
  parameter int unsigned CntWidth = 32,
  parameter int unsigned DivWidth = 16
);
  import state_update_ctrl_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  cmd_op_t             cmd_op;
  logic [CntWidth-1:0] cmd_steps;
  logic [DivWidth-1:0] cmd_period;
  logic                stall;
  logic                upd_en;
  logic                init_req;
  logic                busy;
  logic                done;
  logic                cmd_err;
  logic [CntWidth-1:0] step_count;
`ifdef STATE_UPDATE_CTRL_BKPT_EN
  logic                bkpt_en;
  logic [CntWidth-1:0] bkpt_val;
  logic                bkpt_hit;

  modport master (
    output cmd_valid, cmd_op, cmd_steps, cmd_period, stall, bkpt_en, bkpt_val,
    input  cmd_ready, upd_en, init_req, busy, done, cmd_err, step_count, bkpt_hit
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_steps, cmd_period, stall, bkpt_en, bkpt_val,
    output cmd_ready, upd_en, init_req, busy, done, cmd_err, step_count, bkpt_hit
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_steps, cmd_period, stall,
    input  cmd_ready, upd_en, init_req, busy, done, cmd_err, step_count
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_steps, cmd_period, stall,
    output cmd_ready, upd_en, init_req, busy, done, cmd_err, step_count
  );
`endif

endinterface

// File: rtl/state_update_ctrl_pacer.sv
// update_pacer: reloadable down-counter; o_zero marks an update slot, then it
// reloads to the stored period on the next advance.
module update_pacer #(
  parameter int unsigned DivWidth = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [DivWidth-1:0] i_load_val,
  input  logic                i_adv,
  output logic                o_zero
);

  logic [DivWidth-1:0] r_period;
  logic [DivWidth-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_period <= i_load_val;
      r_cnt    <= i_load_val;
    end else if (i_adv) begin
      r_cnt <= (r_cnt == '0) ? r_period : r_cnt - DivWidth'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/state_update_ctrl.sv
// Command-driven update sequencer: INIT/RUN/STOP/SINGLE over valid/ready.
// Optional breakpoint compare enabled by STATE_UPDATE_CTRL_BKPT_EN.
module state_update_ctrl
  import state_update_ctrl_pkg::*;
#(
  parameter int unsigned CntWidth   = 32,
  parameter int unsigned DivWidth   = 16,
  parameter int unsigned InitCycles = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  state_update_ctrl_if.slave bus
);

  localparam int unsigned InitW = (InitCycles > 1) ? $clog2(InitCycles) : 1;

  state_t              r_state, w_state_d;
  logic                r_upd_en, w_upd_en_d;
  logic                r_init_req, w_init_req_d;
  logic                r_done, w_done_d;
  logic                r_cmd_err, w_cmd_err_d;
  logic [CntWidth-1:0] r_step_count, w_step_count_d;
  logic [CntWidth-1:0] r_steps_left, w_steps_left_d;
  logic [InitW-1:0]    r_init_cnt, w_init_cnt_d;
  logic                w_accept, w_pacer_load, w_pacer_adv, w_pacer_zero;
  logic [DivWidth-1:0] w_load_val;
  logic [CntWidth-1:0] w_step_inc;
`ifdef STATE_UPDATE_CTRL_BKPT_EN
  logic                r_bkpt_hit, w_bkpt_hit_d;
`endif

  update_pacer #(
    .DivWidth(DivWidth)
  ) u_pacer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_pacer_load),
    .i_load_val(w_load_val),
    .i_adv     (w_pacer_adv),
    .o_zero    (w_pacer_zero)
  );

  assign w_accept   = bus.cmd_valid && (r_state != ST_INIT);
  assign w_step_inc = r_step_count + CntWidth'(1);

  always_comb begin
    w_state_d       = r_state;
    w_upd_en_d      = 1'b0;
    w_init_req_d    = 1'b0;
    w_done_d        = 1'b0;
    w_cmd_err_d     = 1'b0;
    w_step_count_d  = r_step_count;
    w_steps_left_d  = r_steps_left;
    w_init_cnt_d    = r_init_cnt;
    w_pacer_load    = 1'b0;
    w_pacer_adv     = 1'b0;
    w_load_val      = bus.cmd_period;
`ifdef STATE_UPDATE_CTRL_BKPT_EN
    w_bkpt_hit_d    = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          unique case (bus.cmd_op)
            OP_INIT: begin
              w_state_d      = ST_INIT;
              w_step_count_d = '0;
              w_init_req_d   = 1'b1;
              w_init_cnt_d   = InitW'(InitCycles - 1);
            end
            OP_RUN: begin
              w_state_d      = ST_RUN;
              w_pacer_load   = 1'b1;
              w_steps_left_d = bus.cmd_steps;
            end
            OP_SINGLE: begin
              w_state_d      = ST_RUN;
              w_pacer_load   = 1'b1;
              w_load_val     = '0;
              w_steps_left_d = CntWidth'(1);
            end
            OP_STOP: ;
            default: ;
          endcase
        end
      end
      ST_INIT: begin
        if (r_init_cnt == '0) begin
          w_state_d = ST_IDLE;
        end else begin
          w_init_cnt_d = r_init_cnt - InitW'(1);
          w_init_req_d = 1'b1;
        end
      end
      ST_RUN: begin
        // STOP wins over both a due update and stall.
        if (w_accept && (bus.cmd_op == OP_STOP)) begin
          w_state_d = ST_IDLE;
        end else begin
          w_cmd_err_d = w_accept;
          if (!bus.stall) begin
            w_pacer_adv = 1'b1;
            if (w_pacer_zero) begin
              w_upd_en_d     = 1'b1;
              w_step_count_d = w_step_inc;
              if (r_steps_left == CntWidth'(1)) begin
                w_done_d  = 1'b1;
                w_state_d = ST_IDLE;
              end else if (r_steps_left != '0) begin
                w_steps_left_d = r_steps_left - CntWidth'(1);
              end
`ifdef STATE_UPDATE_CTRL_BKPT_EN
              if (bus.bkpt_en && (w_step_inc == bus.bkpt_val)) begin
                w_bkpt_hit_d = 1'b1;
                w_state_d    = ST_IDLE;
              end
`endif
            end
          end
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_upd_en     <= 1'b0;
      r_init_req   <= 1'b0;
      r_done       <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_step_count <= '0;
      r_steps_left <= '0;
      r_init_cnt   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_upd_en     <= w_upd_en_d;
      r_init_req   <= w_init_req_d;
      r_done       <= w_done_d;
      r_cmd_err    <= w_cmd_err_d;
      r_step_count <= w_step_count_d;
      r_steps_left <= w_steps_left_d;
      r_init_cnt   <= w_init_cnt_d;
    end
  end

`ifdef STATE_UPDATE_CTRL_BKPT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bkpt_hit <= 1'b0;
    else        r_bkpt_hit <= w_bkpt_hit_d;
  end
  assign bus.bkpt_hit = r_bkpt_hit;
`endif

  assign bus.cmd_ready  = (r_state != ST_INIT);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.upd_en     = r_upd_en;
  assign bus.init_req   = r_init_req;
  assign bus.done       = r_done;
  assign bus.cmd_err    = r_cmd_err;
  assign bus.step_count = r_step_count;

endmodule

// File: tb/tb_state_update_ctrl.sv
// Scoreboarded bench for state_update_ctrl: expected update pulses are queued
// when a command is accepted and matched as upd_en pulses appear.
module tb_state_update_ctrl;
  import state_update_ctrl_pkg::*;

  localparam int unsigned CntW = 4;
  localparam int unsigned DivW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  state_update_ctrl_if #(.CntWidth(CntW), .DivWidth(DivW)) bus ();

  state_update_ctrl #(
    .CntWidth  (CntW),
    .DivWidth  (DivW),
    .InitCycles(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int unsigned    cyc;
    logic [CntW-1:0] step;
    logic           done;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic push(input int unsigned c, input int unsigned step, input logic done);
    exp_t e;
    e.cyc  = c;
    e.step = CntW'(step);
    e.done = done;
    sb.push_back(e);
  endtask

  // Drive a command; k returns the edge number that accepted it.
  task automatic send(input cmd_op_t op, input int unsigned steps, input int unsigned per,
                      output int unsigned k);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_steps  = CntW'(steps);
    bus.cmd_period = DivW'(per);
    @(posedge clk);
    #1;
    k = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic goto(input int unsigned target);
    do @(negedge clk); while (cyc < target);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.upd_en) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_upd_en", bus.upd_en, 0);
      end else begin
        e = sb.pop_front();
        check_eq("upd_cycle", cyc, e.cyc);
        check_eq("upd_step", bus.step_count, e.step);
        check_eq("upd_done", bus.done, e.done);
      end
    end else if (bus.done) begin
      check_eq("done_without_upd", bus.done, 0);
    end
  end

  initial begin
    int unsigned k, k2;
    int n_init, n_busy, n_rdy_lo;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = OP_STOP;
    bus.cmd_steps  = '0;
    bus.cmd_period = '0;
    bus.stall      = 1'b0;
`ifdef STATE_UPDATE_CTRL_BKPT_EN
    bus.bkpt_en    = 1'b0;
    bus.bkpt_val   = '0;
`endif
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check_eq("rst_upd_en", bus.upd_en, 0);
    check_eq("rst_init_req", bus.init_req, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_step", bus.step_count, 0);
    check_eq("rst_done_err", {bus.done, bus.cmd_err}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", bus.cmd_ready, 1);

    // INIT: init_req/busy high 2 cycles, ready low meanwhile
    send(OP_INIT, 0, 0, k);
    n_init = 0; n_busy = 0; n_rdy_lo = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_init   += int'(bus.init_req);
      n_busy   += int'(bus.busy);
      n_rdy_lo += int'(!bus.cmd_ready);
    end
    check_eq("init_req_cycles", n_init, 2);
    check_eq("init_busy_cycles", n_busy, 2);
    check_eq("init_ready_low", n_rdy_lo, 2);
    check_eq("init_step", bus.step_count, 0);

    // Bounded run: steps=3, P=2
    send(OP_RUN, 3, 2, k);
    push(k + 3, 1, 0); push(k + 6, 2, 0); push(k + 9, 3, 1);
    goto(k + 8);
    check_eq("run3_busy_before", bus.busy, 1);
    goto(k + 9);
    check_eq("run3_busy_after", bus.busy, 0);
    check_eq("run3_step", bus.step_count, 3);

    // Stall for 5 cycles after first update
    send(OP_RUN, 4, 0, k);
    push(k + 1, 4, 0); push(k + 7, 5, 0); push(k + 8, 6, 0); push(k + 9, 7, 1);
    goto(k + 1);
    bus.stall = 1'b1;
    goto(k + 6);
    bus.stall = 1'b0;
    goto(k + 8);
    check_eq("stall_busy_before", bus.busy, 1);
    goto(k + 9);
    check_eq("stall_busy_after", bus.busy, 0);
    check_eq("stall_step", bus.step_count, 7);

    // Free-run P=1, STOP on an update-due edge
    send(OP_RUN, 0, 1, k);
    push(k + 2, 8, 0); push(k + 4, 9, 0);
    goto(k + 5);
    send(OP_STOP, 0, 0, k2);
    check_eq("stop_accept_edge", k2, k + 6);
    goto(k2);
    check_eq("stop_upd_en", bus.upd_en, 0);
    check_eq("stop_done", bus.done, 0);
    check_eq("stop_busy", bus.busy, 0);
    check_eq("stop_step", bus.step_count, 9);
    send(OP_STOP, 0, 0, k2);
    goto(k2);
    check_eq("idle_stop_err", bus.cmd_err, 0);

    // Illegal RUN while running
    send(OP_RUN, 2, 1, k);
    push(k + 2, 10, 0); push(k + 4, 11, 1);
    send(OP_RUN, 3, 0, k2);
    goto(k2);
    check_eq("err_pulse", bus.cmd_err, 1);
    goto(k2 + 1);
    check_eq("err_pulse_end", bus.cmd_err, 0);
    goto(k + 4);
    check_eq("err_run_busy", bus.busy, 0);
    check_eq("err_run_step", bus.step_count, 11);

    // Count up to 15, then SINGLE wraps to 0
    send(OP_RUN, 4, 0, k);
    for (int i = 1; i <= 4; i++) push(k + i, 11 + i, i == 4);
    goto(k + 4);
    check_eq("wrap_pre_step", bus.step_count, 15);
    send(OP_SINGLE, 0, 0, k2);
    push(k2 + 1, 0, 1);
    goto(k2 + 1);
    check_eq("wrap_step", bus.step_count, 0);
    check_eq("wrap_busy", bus.busy, 0);

    // Reset mid-run with step_count = 5
    send(OP_INIT, 0, 0, k);
    goto(k + 2);
    check_eq("reinit_busy", bus.busy, 0);
    send(OP_RUN, 0, 0, k);
    for (int i = 1; i <= 5; i++) push(k + i, i, 0);
    goto(k + 5);
    check_eq("pre_rst_step", bus.step_count, 5);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outputs",
             {bus.upd_en, bus.init_req, bus.done, bus.cmd_err, bus.busy}, 0);
    check_eq("midrst_step", bus.step_count, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    send(OP_SINGLE, 0, 0, k2);
    push(k2 + 1, 1, 1);
    goto(k2 + 3);
    check_eq("post_rst_step", bus.step_count, 1);
    check_eq("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/state_update_ctrl.md
Name: state_update_ctrl

Overview:
Sequences the update strobe for a bank of clocked state registers in an emulated model, so the model advances on command rather than every clock. Accepts INIT/RUN/STOP/SINGLE commands over a valid/ready handshake. Paces updates by a programmable divider, honours a downstream stall, and keeps a step counter. Sits between the host/test controller and the model's state-register clock enables and init inputs.

Parameters:
cnt_width, 32, width of step limit and step counter
div_width, 16, width of pacing period
init_cycles, 2, cycles init_req is held during INIT (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when valid&&ready at clk edge
cmd_op  input  2  0=INIT, 1=RUN, 2=STOP, 3=SINGLE
cmd_steps  input  cnt_width  RUN step limit; 0 = free-run
cmd_period  input  div_width  RUN pacing P: one update per P+1 unstalled cycles
stall  input  1  downstream back-pressure; freezes pacing
upd_en  output  1  registered clock-enable to state registers
init_req  output  1  registered init-load request to state registers
busy  output  1  state != IDLE (combinational from state reg)
done  output  1  1-cycle pulse with final upd_en of a bounded run
cmd_err  output  1  1-cycle pulse: illegal command dropped
step_count  output  cnt_width  updates issued since last INIT

Behaviour:
- Reset (rst=0, async): state=IDLE; upd_en, init_req, done, cmd_err = 0; step_count = 0; div_cnt and steps_left = 0. After release, cmd_ready=1.
- States: IDLE, INIT, RUN. cmd_ready = (state != INIT).
- IDLE, INIT accepted: state=INIT, step_count<=0, init_req high for exactly init_cycles cycles starting at the cycle after the accept edge, then IDLE. upd_en stays 0.
- IDLE, RUN accepted: div_cnt<=cmd_period, steps_left<=cmd_steps, state=RUN.
- IDLE, SINGLE accepted: same as RUN with P=0 and steps=1.
- IDLE, STOP: no-op, no error.
- RUN, each edge with stall=0:
  - If div_cnt==0: upd_en<=1, step_count++ (wraps 2^cnt_width-1 -> 0), div_cnt<=P.
    - If steps_left==1: also done<=1 and state<=IDLE.
    - Else if steps_left!=0: steps_left--.
  - Otherwise: upd_en<=0, div_cnt--.
- Latency: the first upd_en follows accept edge k at edge k+P+1; later pulses repeat every P+1 unstalled cycles.
- stall=1 at an edge in RUN: upd_en<=0; div_cnt, steps_left and step_count hold.
- STOP accepted in RUN: state<=IDLE, upd_en<=0, and no done. STOP overrides any update due that edge and overrides stall.
- INIT/RUN/SINGLE accepted in RUN: dropped, cmd_err<=1 for one cycle, run continues unaffected.
- Free-run (steps=0) ends only by STOP or reset.
- Reset asserted mid-RUN or mid-INIT: immediate return to reset values; the partial run is discarded.

Optional Feature:
STATE_UPDATE_CTRL_BKPT_EN
- Defined: adds ports bkpt_en (in, 1), bkpt_val (in, cnt_width) and bkpt_hit (out, 1, reset 0).
  - In RUN, when an update is issued and bkpt_en=1 and the new step_count == bkpt_val: state<=IDLE and bkpt_hit pulses 1 cycle, coincident with that upd_en.
  - done pulses too if the run also ended on that step.
- Undefined: ports absent; no breakpoint logic.

Decomposition:
- Package state_update_ctrl_pkg holds:
  - cmd_op_t enum: OP_INIT, OP_RUN, OP_STOP, OP_SINGLE.
  - state_t enum: ST_IDLE, ST_INIT, ST_RUN.
- One sub-module: update_pacer, the reloadable down-counter with load, hold (stall) and tick-on-zero outputs, parameterised by div_width.
- FSM, step counting and handshake stay in the top.

Test Plan:
- Reset then INIT (init_cycles=2) -> init_req high exactly 2 cycles, busy high 2 cycles, step_count=0, cmd_ready low during INIT.
- RUN steps=3 P=2 accepted at edge k -> upd_en pulses after edges k+3, k+6, k+9; done coincident with third; step_count=3; busy drops with it.
- RUN steps=4 P=0 with stall high for 5 cycles after first update -> exactly 4 upd_en pulses; none during stall; completes 5 cycles late.
- Free-run P=1, STOP on the edge an update is due -> no upd_en that cycle, no done, state IDLE; STOP in IDLE gives no cmd_err.
- RUN then RUN again while running -> cmd_err 1-cycle pulse, original run unaffected; preset step_count to 2^cnt_width-1 (cnt_width=4, 15 steps) then SINGLE -> wraps to 0.
- rst pulled low mid-RUN (step_count=5) -> all outputs 0 immediately; after release the next SINGLE gives step_count=1.
